// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - runs the rounds of one binary-math game session: target fetch, answer check, score, countdown
// Optional build macro WRONG_PENALTY_EN: a wrong answer also removes PENALTY_SEC seconds from the clock.
module round_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int GAME_SECONDS  = 60,
  parameter int OPERAND_W     = 8,
  parameter int SCORE_W       = 8,
  parameter int PENALTY_SEC   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 reconfig_i,
  input  logic                 load_i,
  input  logic [OPERAND_W-1:0] player_answer_i,
  input  logic                 rng_valid_i,
  input  logic [OPERAND_W-1:0] rng_value_i,
  output logic                 rng_req_o,
  output logic [OPERAND_W-1:0] target_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [7:0]           time_left_o,
  output logic                 time_up_o,
  output logic                 correct_o,
  output logic                 wrong_o
);

  localparam int                 PW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]      PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]         TIME_INIT = 8'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [8:0]         PENALTY   = 9'(PENALTY_SEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ANS,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 rng_req_q, rng_req_d;
  logic [OPERAND_W-1:0] target_q, target_d;
  logic [OPERAND_W-1:0] answer_q, answer_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           time_left_q, time_left_d;
  logic                 time_up_q, time_up_d;
  logic                 correct_q, correct_d;
  logic                 wrong_q, wrong_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 load_q;

  logic                 press;
  logic                 in_round;
  logic                 timer_run;
  logic                 wrap;
  logic                 answer_ok;
  logic [PW-1:0]        presc_next;
  logic [8:0]           pen_total;
  logic [7:0]           pen_time;
  logic                 pen_hit;

  // A held submit button counts once: only the rising edge is a press.
  assign press      = load_i & ~load_q;
  assign in_round   = (state_q == S_REQ) || (state_q == S_WAIT_ANS) || (state_q == S_CHECK);
  assign timer_run  = enable_i && in_round;
  assign wrap       = timer_run && (presc_q == PRESC_MAX);
  assign answer_ok  = (answer_q == target_q);
  assign presc_next = wrap ? '0 : presc_q + PW'(1);

  // Penalty path: the seconds removed include the normal one-second tick when it lands in CHECK.
  assign pen_total = PENALTY + {8'd0, wrap};
  assign pen_time  = ({1'b0, time_left_q} > pen_total) ? 8'({1'b0, time_left_q} - pen_total) : 8'd0;

`ifdef WRONG_PENALTY_EN
  assign pen_hit = enable_i && (state_q == S_CHECK) && !answer_ok;
`else
  assign pen_hit = 1'b0;
`endif

  // Next-state: reconfig first, then penalty/expiry, then enable drop, then the round FSM.
  always_comb begin
    state_d     = state_q;
    rng_req_d   = rng_req_q;
    target_d    = target_q;
    answer_d    = answer_q;
    score_d     = score_q;
    time_left_d = time_left_q;
    time_up_d   = time_up_q;
    presc_d     = presc_q;
    correct_d   = 1'b0;
    wrong_d     = 1'b0;

    if (reconfig_i) begin
      score_d     = '0;
      time_left_d = TIME_INIT;
      presc_d     = '0;
      time_up_d   = 1'b1;
      rng_req_d   = 1'b0;
      state_d     = S_IDLE;
    end else if (pen_hit) begin
      presc_d     = presc_next;
      time_left_d = pen_time;
      wrong_d     = 1'b1;
      if (pen_time == 8'd0) begin
        time_up_d = 1'b0;
        rng_req_d = 1'b0;
        state_d   = S_DONE;
      end else begin
        rng_req_d = 1'b1;
        state_d   = S_REQ;
      end
    end else if (wrap && (time_left_q == 8'd1)) begin
      // Clock ran out: whatever round was in flight is dropped without scoring.
      presc_d     = presc_next;
      time_left_d = 8'd0;
      time_up_d   = 1'b0;
      rng_req_d   = 1'b0;
      state_d     = S_DONE;
    end else if (!enable_i) begin
      if (in_round) begin
        state_d   = S_IDLE;
        rng_req_d = 1'b0;
      end
    end else begin
      if (timer_run) begin
        presc_d = presc_next;
        if (wrap) begin
          time_left_d = time_left_q - 8'd1;
        end
      end
      unique case (state_q)
        S_IDLE: begin
          if (time_up_q) begin
            rng_req_d = 1'b1;
            state_d   = S_REQ;
          end
        end
        S_REQ: begin
          if (rng_valid_i) begin
            target_d  = rng_value_i;
            rng_req_d = 1'b0;
            state_d   = S_WAIT_ANS;
          end
        end
        S_WAIT_ANS: begin
          if (press) begin
            answer_d = player_answer_i;
            state_d  = S_CHECK;
          end
        end
        S_CHECK: begin
          if (answer_ok) begin
            correct_d = 1'b1;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            wrong_d = 1'b1;
          end
          rng_req_d = 1'b1;
          state_d   = S_REQ;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d   = S_IDLE;
          rng_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; the button history tracks Load every cycle regardless of state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rng_req_q   <= 1'b0;
      target_q    <= '0;
      answer_q    <= '0;
      score_q     <= '0;
      time_left_q <= TIME_INIT;
      time_up_q   <= 1'b1;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      presc_q     <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rng_req_q   <= rng_req_d;
      target_q    <= target_d;
      answer_q    <= answer_d;
      score_q     <= score_d;
      time_left_q <= time_left_d;
      time_up_q   <= time_up_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      presc_q     <= presc_d;
      load_q      <= load_i;
    end
  end

  assign rng_req_o   = rng_req_q;
  assign target_o    = target_q;
  assign score_o     = score_q;
  assign time_left_o = time_left_q;
  assign time_up_o   = time_up_q;
  assign correct_o   = correct_q;
  assign wrong_o     = wrong_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer against a session-level reference model
module tb_round_sequencer;

  localparam int TICKS = 4;
  localparam int GAME  = 3;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_CHECK = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst, en, rc, ld, rv;
  logic [7:0] pa, rval;
  logic       rng_req_o, time_up_o, correct_o, wrong_o;
  logic [7:0] target_o, score_o, time_left_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: session progress is tracked as the number of active game-clock cycles used.
  int         m_phase, m_act, m_score;
  logic [7:0] m_target, m_ans;
  bit         m_req, m_corr, m_wrong, m_lprev;

  round_sequencer #(
    .TICKS_PER_SEC(TICKS),
    .GAME_SECONDS (GAME),
    .OPERAND_W    (8),
    .SCORE_W      (8),
    .PENALTY_SEC  (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (en),
    .reconfig_i     (rc),
    .load_i         (ld),
    .player_answer_i(pa),
    .rng_valid_i    (rv),
    .rng_value_i    (rval),
    .rng_req_o      (rng_req_o),
    .target_o       (target_o),
    .score_o        (score_o),
    .time_left_o    (time_left_o),
    .time_up_o      (time_up_o),
    .correct_o      (correct_o),
    .wrong_o        (wrong_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int exp_tl();
    return GAME - (m_act / TICKS);
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_act = 0; m_score = 0; m_target = 8'd0; m_ans = 8'd0;
    m_req = 1'b0; m_corr = 1'b0; m_wrong = 1'b0; m_lprev = 1'b0;
  endfunction

  function automatic void model_step();
    bit press;
    bit running;
    press   = ld && !m_lprev;
    m_lprev = ld;
    m_corr  = 1'b0;
    m_wrong = 1'b0;
    if (rst) begin model_reset(); return; end
    if (rc) begin
      m_score = 0; m_act = 0; m_req = 1'b0; m_phase = P_IDLE;
      return;
    end
    running = en && (m_phase == P_REQ || m_phase == P_WAIT || m_phase == P_CHECK);
    if (running) m_act++;
    if (running && m_act == GAME * TICKS) begin
      m_phase = P_DONE; m_req = 1'b0;
      return;
    end
    if (!en) begin
      if (m_phase != P_DONE && m_phase != P_IDLE) begin m_phase = P_IDLE; m_req = 1'b0; end
      return;
    end
    case (m_phase)
      P_IDLE:  if (exp_tl() != 0) begin m_phase = P_REQ; m_req = 1'b1; end
      P_REQ:   if (rv) begin m_target = rval; m_req = 1'b0; m_phase = P_WAIT; end
      P_WAIT:  if (press) begin m_ans = pa; m_phase = P_CHECK; end
      P_CHECK: begin
        if (m_ans == m_target) begin
          m_corr = 1'b1;
          if (m_score < 255) m_score++;
        end else begin
          m_wrong = 1'b1;
        end
        m_phase = P_REQ; m_req = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_session(input logic [7:0] t);
    rc = 1'b1; en = 1'b0; ld = 1'b0; rv = 1'b0;
    tick();
    rc = 1'b0; en = 1'b1;
    tick();
    rv = 1'b1; rval = t;
    tick();
    rv = 1'b0;
  endtask

  task automatic press(input logic [7:0] v);
    pa = v; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rc = 1'b0; ld = 1'b0; rv = 1'b0; pa = 8'd0; rval = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL reset_rngreq got=%b want=0", rng_req_o); end
    checks++; if (target_o !== 8'd0) begin failures++; $display("FAIL reset_target got=%h want=00", target_o); end
    checks++; if (score_o !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d want=0", score_o); end
    checks++; if (time_left_o !== 8'd3) begin failures++; $display("FAIL reset_timeleft got=%0d want=3", time_left_o); end
    checks++; if (time_up_o !== 1'b1) begin failures++; $display("FAIL reset_timeup got=%b want=1", time_up_o); end
    checks++; if ({correct_o, wrong_o} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b%b want=00", correct_o, wrong_o); end
  endtask

  task automatic test_first_round();
    rc = 1'b1;
    tick();
    rc = 1'b0; en = 1'b1; rv = 1'b1; rval = 8'h2A;
    tick();
    checks++; if (rng_req_o !== 1'b1) begin failures++; $display("FAIL first_req_rise got=%b want=1", rng_req_o); end
    tick();
    rv = 1'b0;
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL first_req_fall got=%b want=0", rng_req_o); end
    checks++; if (target_o !== 8'h2A) begin failures++; $display("FAIL first_target got=%h want=2a", target_o); end
    tick();
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL first_req_wait got=%b want=0", rng_req_o); end
  endtask

  task automatic test_hold_load();
    int n_c, n_w, pos;
    n_c = 0; n_w = 0; pos = -1;
    start_session(8'h2A);
    pa = 8'h2A; ld = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (correct_o === 1'b1) begin n_c++; if (pos < 0) pos = i; end
      if (wrong_o === 1'b1) n_w++;
      if (i == 2) begin
        checks++; if (score_o !== 8'd1) begin failures++; $display("FAIL hold_score got=%0d want=1", score_o); end
        checks++; if (rng_req_o !== 1'b1) begin failures++; $display("FAIL hold_next_req got=%b want=1", rng_req_o); end
      end
    end
    ld = 1'b0;
    checks++; if (n_c != 1) begin failures++; $display("FAIL hold_pulse_count got=%0d want=1", n_c); end
    checks++; if (pos != 2) begin failures++; $display("FAIL hold_pulse_latency got=%0d want=2", pos); end
    checks++; if (n_w != 0) begin failures++; $display("FAIL hold_wrong_count got=%0d want=0", n_w); end
  endtask

  task automatic test_wrong();
    start_session(8'h2A);
    press(8'h2A);
    checks++; if (correct_o !== 1'b1) begin failures++; $display("FAIL wrong_setup_correct got=%b want=1", correct_o); end
    rv = 1'b1; rval = 8'h2A;
    tick();
    rv = 1'b0;
    press(8'h15);
    checks++; if ({correct_o, wrong_o} !== 2'b01) begin failures++; $display("FAIL wrong_pulse got=%b%b want=01", correct_o, wrong_o); end
    checks++; if (score_o !== 8'd1) begin failures++; $display("FAIL wrong_score got=%0d want=1", score_o); end
    checks++; if (time_left_o !== 8'(exp_tl())) begin failures++; $display("FAIL wrong_timeleft got=%0d want=%0d", time_left_o, exp_tl()); end
  endtask

  task automatic test_expiry();
    int pulses;
    pulses = 0;
    start_session(8'h2A);
    repeat (3) tick();
    checks++; if (time_left_o !== 8'd2) begin failures++; $display("FAIL expiry_t4 got=%0d want=2", time_left_o); end
    repeat (4) tick();
    checks++; if (time_left_o !== 8'd1) begin failures++; $display("FAIL expiry_t8 got=%0d want=1", time_left_o); end
    repeat (3) tick();
    checks++; if (time_up_o !== 1'b1) begin failures++; $display("FAIL expiry_t11_timeup got=%b want=1", time_up_o); end
    tick();
    checks++; if (time_left_o !== 8'd0) begin failures++; $display("FAIL expiry_t12 got=%0d want=0", time_left_o); end
    checks++; if (time_up_o !== 1'b0) begin failures++; $display("FAIL expiry_timeup got=%b want=0", time_up_o); end
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL expiry_req got=%b want=0", rng_req_o); end
    for (int k = 0; k < 3; k++) begin
      press(8'h2A);
      if (correct_o === 1'b1 || wrong_o === 1'b1) pulses++;
      tick();
      if (correct_o === 1'b1 || wrong_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL expiry_late_pulses got=%0d want=0", pulses); end
    checks++; if (score_o !== 8'd0) begin failures++; $display("FAIL expiry_score got=%0d want=0", score_o); end
  endtask

  task automatic test_press_at_expiry();
    start_session(8'h2A);
    repeat (9) tick();
    pa = 8'h2A; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    checks++; if ({correct_o, wrong_o} !== 2'b00) begin failures++; $display("FAIL pexp_pulse got=%b%b want=00", correct_o, wrong_o); end
    checks++; if (time_up_o !== 1'b0) begin failures++; $display("FAIL pexp_timeup got=%b want=0", time_up_o); end
    tick();
    checks++; if ({correct_o, wrong_o} !== 2'b00) begin failures++; $display("FAIL pexp_pulse_late got=%b%b want=00", correct_o, wrong_o); end
    checks++; if (score_o !== 8'd0) begin failures++; $display("FAIL pexp_score got=%0d want=0", score_o); end
    rc = 1'b1;
    tick();
    rc = 1'b0;
    checks++; if (score_o !== 8'd0) begin failures++; $display("FAIL reconf_score got=%0d want=0", score_o); end
    checks++; if (time_left_o !== 8'd3) begin failures++; $display("FAIL reconf_timeleft got=%0d want=3", time_left_o); end
    checks++; if (time_up_o !== 1'b1) begin failures++; $display("FAIL reconf_timeup got=%b want=1", time_up_o); end
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL reconf_req got=%b want=0", rng_req_o); end
    tick();
    checks++; if (rng_req_o !== 1'b1) begin failures++; $display("FAIL reconf_idle_to_req got=%b want=1", rng_req_o); end
  endtask

  task automatic test_enable_drop();
    int bad;
    bad = 0;
    start_session(8'h2A);
    repeat (2) tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (time_left_o !== 8'd3 || rng_req_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL endrop_hold got=%0d bad cycles want=0", bad); end
    en = 1'b1;
    tick();
    checks++; if (rng_req_o !== 1'b1) begin failures++; $display("FAIL endrop_req got=%b want=1", rng_req_o); end
    rv = 1'b1; rval = 8'h55;
    tick();
    rv = 1'b0;
    checks++; if (time_left_o !== 8'd2) begin failures++; $display("FAIL endrop_presc_resume got=%0d want=2", time_left_o); end
    checks++; if (target_o !== 8'h55) begin failures++; $display("FAIL endrop_target got=%h want=55", target_o); end
  endtask

  task automatic test_async_reset();
    rc = 1'b1;
    tick();
    rc = 1'b0; en = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rng_req_o !== 1'b0) begin failures++; $display("FAIL areset_req got=%b want=0", rng_req_o); end
    checks++; if (target_o !== 8'd0) begin failures++; $display("FAIL areset_target got=%h want=00", target_o); end
    checks++; if (time_left_o !== 8'd3 || time_up_o !== 1'b1) begin failures++; $display("FAIL areset_time got=%0d/%b want=3/1", time_left_o, time_up_o); end
    checks++; if (score_o !== 8'd0) begin failures++; $display("FAIL areset_score got=%0d want=0", score_o); end
    model_reset();
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    rc = 1'b1;
    tick();
    for (int k = 0; k < 800; k++) begin
      rc   = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 9) != 0);
      ld   = ($urandom_range(0, 2) == 0);
      rv   = ($urandom_range(0, 1) == 0);
      rval = 8'($urandom_range(0, 7));
      pa   = ($urandom_range(0, 1) == 0) ? m_target : 8'($urandom_range(0, 7));
      tick();
      checks++;
      if ({rng_req_o, target_o, score_o, time_left_o, time_up_o, correct_o, wrong_o} !==
          {m_req, m_target, 8'(m_score), 8'(exp_tl()), (exp_tl() != 0), m_corr, m_wrong}) begin
        failures++;
        $display("FAIL random_cycle%0d got req=%b tgt=%h sc=%0d tl=%0d tu=%b c=%b w=%b want req=%b tgt=%h sc=%0d tl=%0d tu=%b c=%b w=%b",
                 k, rng_req_o, target_o, score_o, time_left_o, time_up_o, correct_o, wrong_o,
                 m_req, m_target, m_score, exp_tl(), (exp_tl() != 0), m_corr, m_wrong);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_round();
    test_hold_load();
    test_wrong();
    test_expiry();
    test_press_at_expiry();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
